// File: rtl/wb_stage.sv
// MEM/WB writeback stage: captures retiring instructions, waits on loads, extends load data and drives the regfile write port.
// Optional load-wait timeout is enabled by defining LOAD_TIMEOUT_EN.
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_Valid,
  output logic        WB_Ready,
  input  logic        MEM_Reg_Write,
  input  logic [4:0]  MEM_RD_Addr,
  input  logic        MEM_IRQ,
  input  logic        MEM_Is_Load,
  input  logic [2:0]  MEM_Funct3,
  input  logic [1:0]  MEM_Addr_Lo,
  input  logic [31:0] MEM_ALU_Result,
  input  logic        DMEM_RValid,
  input  logic [31:0] DMEM_RData,
  output logic [4:0]  RD_Write_Addr,
  output logic [31:0] RD_Write_Data,
  output logic        Reg_Write_Enable__EX_MEM,
  output logic        MEM_WB_Freeze,
  output logic        WB_Ctrl__IRQ,
  output logic        Fwd_Valid,
  output logic [4:0]  Fwd_Addr,
  output logic [31:0] Fwd_Data,
  output logic        Fwd_Pending,
  output logic        Load_Misalign_Err,
  output logic        Load_Timeout_Err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic TIMEOUT_CFG_OK = 1'(TIMEOUT_CYCLES < (1 << TIMEOUT_W));

  state_t      state_r, state_s;
  logic [4:0]  rd_addr_r, rd_addr_s;
  logic [31:0] data_r, data_s;
  logic        reg_write_r, reg_write_s;
  logic        irq_r, irq_s;
  logic [2:0]  funct3_r, funct3_s;
  logic [1:0]  lo_r, lo_s;
  logic        misalign_r, misalign_s;
  logic        timeout_err_r, timeout_err_s;
  logic        timeout_hit_s;

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b001, 3'b101: load_misaligned = lo[0];
      3'b010:         load_misaligned = (lo != 2'b00);
      default:        load_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

`ifdef LOAD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_r;

  // Counts WAIT cycles; held at zero outside WAIT so each load starts fresh.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  assign timeout_hit_s = TIMEOUT_CFG_OK && (cnt_r == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0 & TIMEOUT_CFG_OK;
`endif

  // Next-state and next-register values.
  always_comb begin
    state_s       = state_r;
    rd_addr_s     = rd_addr_r;
    data_s        = data_r;
    reg_write_s   = reg_write_r;
    irq_s         = irq_r;
    funct3_s      = funct3_r;
    lo_s          = lo_r;
    misalign_s    = 1'b0;
    timeout_err_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (DMEM_RValid) begin
          state_s = ST_FULL;
          data_s  = load_extend(funct3_r, lo_r, DMEM_RData);
        end else if (timeout_hit_s) begin
          state_s       = ST_EMPTY;
          timeout_err_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_EMPTY, ST_FULL: begin
        if (MEM_Valid) begin
          if (MEM_Is_Load) begin
            if (load_misaligned(MEM_Funct3, MEM_Addr_Lo)) begin
              state_s    = ST_EMPTY;
              misalign_s = 1'b1;
            end else begin
              state_s     = ST_WAIT;
              rd_addr_s   = MEM_RD_Addr;
              reg_write_s = MEM_Reg_Write;
              irq_s       = MEM_IRQ;
              funct3_s    = MEM_Funct3;
              lo_s        = MEM_Addr_Lo;
            end
          end else begin
            state_s     = ST_FULL;
            rd_addr_s   = MEM_RD_Addr;
            data_s      = MEM_ALU_Result;
            reg_write_s = MEM_Reg_Write;
            irq_s       = MEM_IRQ;
          end
        end else begin
          state_s = ST_EMPTY;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Writeback payload and error pulse registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_addr_r     <= 5'd0;
      data_r        <= 32'd0;
      reg_write_r   <= 1'b0;
      irq_r         <= 1'b0;
      funct3_r      <= 3'd0;
      lo_r          <= 2'd0;
      misalign_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      rd_addr_r     <= rd_addr_s;
      data_r        <= data_s;
      reg_write_r   <= reg_write_s;
      irq_r         <= irq_s;
      funct3_r      <= funct3_s;
      lo_r          <= lo_s;
      misalign_r    <= misalign_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign WB_Ready                 = (state_r != ST_WAIT);
  assign MEM_WB_Freeze            = (state_r == ST_WAIT);
  assign RD_Write_Addr            = rd_addr_r;
  assign RD_Write_Data            = data_r;
  assign WB_Ctrl__IRQ             = irq_r;
  assign Reg_Write_Enable__EX_MEM = (state_r == ST_FULL) && reg_write_r && (rd_addr_r != 5'd0);
  assign Fwd_Valid                = Reg_Write_Enable__EX_MEM;
  assign Fwd_Addr                 = rd_addr_r;
  assign Fwd_Data                 = data_r;
  // Decode must stall on a younger reader until the load returns.
  assign Fwd_Pending              = (state_r == ST_WAIT) && reg_write_r && (rd_addr_r != 5'd0);
  assign Load_Misalign_Err        = misalign_r;
  assign Load_Timeout_Err         = timeout_err_r;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed stimulus pushes expected writeback events, a monitor pops and compares.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MEM_Valid, WB_Ready, MEM_Reg_Write, MEM_IRQ, MEM_Is_Load;
  logic [4:0]  MEM_RD_Addr;
  logic [2:0]  MEM_Funct3;
  logic [1:0]  MEM_Addr_Lo;
  logic [31:0] MEM_ALU_Result;
  logic        DMEM_RValid;
  logic [31:0] DMEM_RData;
  logic [4:0]  RD_Write_Addr, Fwd_Addr;
  logic [31:0] RD_Write_Data, Fwd_Data;
  logic        Reg_Write_Enable__EX_MEM, MEM_WB_Freeze, WB_Ctrl__IRQ;
  logic        Fwd_Valid, Fwd_Pending, Load_Misalign_Err, Load_Timeout_Err;

  wb_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEM_Valid(MEM_Valid), .WB_Ready(WB_Ready),
    .MEM_Reg_Write(MEM_Reg_Write), .MEM_RD_Addr(MEM_RD_Addr), .MEM_IRQ(MEM_IRQ),
    .MEM_Is_Load(MEM_Is_Load), .MEM_Funct3(MEM_Funct3), .MEM_Addr_Lo(MEM_Addr_Lo),
    .MEM_ALU_Result(MEM_ALU_Result), .DMEM_RValid(DMEM_RValid), .DMEM_RData(DMEM_RData),
    .RD_Write_Addr(RD_Write_Addr), .RD_Write_Data(RD_Write_Data),
    .Reg_Write_Enable__EX_MEM(Reg_Write_Enable__EX_MEM), .MEM_WB_Freeze(MEM_WB_Freeze),
    .WB_Ctrl__IRQ(WB_Ctrl__IRQ), .Fwd_Valid(Fwd_Valid), .Fwd_Addr(Fwd_Addr),
    .Fwd_Data(Fwd_Data), .Fwd_Pending(Fwd_Pending), .Load_Misalign_Err(Load_Misalign_Err),
    .Load_Timeout_Err(Load_Timeout_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic        mis;
    logic        to;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [31:0] data, input logic irq);
    exp_t e;
    e.en = 1'b1; e.mis = 1'b0; e.to = 1'b0; e.addr = addr; e.data = data; e.irq = irq;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic mis, input logic to);
    exp_t e;
    e.en = 1'b0; e.mis = mis; e.to = to; e.addr = 5'd0; e.data = 32'd0; e.irq = 1'b0;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic is_load, input logic rw, input logic [4:0] rd, input logic irq,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res);
    MEM_Valid = 1'b1; MEM_Is_Load = is_load; MEM_Reg_Write = rw; MEM_RD_Addr = rd;
    MEM_IRQ = irq; MEM_Funct3 = f3; MEM_Addr_Lo = lo; MEM_ALU_Result = res;
  endtask

  task automatic idle();
    MEM_Valid = 1'b0; MEM_Is_Load = 1'b0; MEM_Reg_Write = 1'b0; MEM_RD_Addr = 5'd0;
    MEM_IRQ = 1'b0; MEM_Funct3 = 3'd0; MEM_Addr_Lo = 2'd0; MEM_ALU_Result = 32'd0;
  endtask

  task automatic load_with_data(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                                input logic [31:0] rdata, input logic [31:0] exp_data);
    issue(1'b1, 1'b1, rd, 1'b0, f3, lo, 32'd0);
    step();
    idle();
    check("load_freeze", {31'd0, MEM_WB_Freeze}, 32'd1);
    DMEM_RValid = 1'b1; DMEM_RData = rdata;
    push_wr(rd, exp_data, 1'b0);
    step();
    DMEM_RValid = 1'b0; DMEM_RData = 32'd0;
    step();
  endtask

  // Monitor: every presented writeback or error pulse must match the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && (Reg_Write_Enable__EX_MEM || Load_Misalign_Err || Load_Timeout_Err)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: en=%0b mis=%0b to=%0b addr=%0d, expected no event",
                 Reg_Write_Enable__EX_MEM, Load_Misalign_Err, Load_Timeout_Err, RD_Write_Addr);
      end else begin
        mon_e = sb.pop_front();
        check("wb_enable", {31'd0, Reg_Write_Enable__EX_MEM}, {31'd0, mon_e.en});
        check("misalign_err", {31'd0, Load_Misalign_Err}, {31'd0, mon_e.mis});
        check("timeout_err", {31'd0, Load_Timeout_Err}, {31'd0, mon_e.to});
        if (mon_e.en) begin
          check("wb_addr", {27'd0, RD_Write_Addr}, {27'd0, mon_e.addr});
          check("wb_data", RD_Write_Data, mon_e.data);
          check("wb_irq", {31'd0, WB_Ctrl__IRQ}, {31'd0, mon_e.irq});
          check("fwd_valid", {31'd0, Fwd_Valid}, 32'd1);
          check("fwd_addr", {27'd0, Fwd_Addr}, {27'd0, mon_e.addr});
          check("fwd_data", Fwd_Data, mon_e.data);
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    idle();
    DMEM_RValid = 1'b0; DMEM_RData = 32'd0;
    step();
    check("rst_ready", {31'd0, WB_Ready}, 32'd1);
    check("rst_freeze", {31'd0, MEM_WB_Freeze}, 32'd0);
    check("rst_enable", {31'd0, Reg_Write_Enable__EX_MEM}, 32'd0);
    check("rst_addr", {27'd0, RD_Write_Addr}, 32'd0);
    check("rst_data", RD_Write_Data, 32'd0);
    check("rst_misc", {26'd0, WB_Ctrl__IRQ, Fwd_Valid, Fwd_Pending, Load_Misalign_Err,
                       Load_Timeout_Err, |Fwd_Data}, 32'd0);
    RST_N = 1'b1;
    step();

    // ADD rd=5 -> one-cycle write
    issue(1'b0, 1'b1, 5'd5, 1'b0, 3'd0, 2'd0, 32'h0000_1234);
    push_wr(5'd5, 32'h0000_1234, 1'b0);
    step();
    idle();
    step();
    check("add_enable_drops", {31'd0, Reg_Write_Enable__EX_MEM}, 32'd0);

    // LB lo=3 with three wait cycles
    issue(1'b1, 1'b1, 5'd9, 1'b0, 3'b000, 2'd3, 32'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("lb_freeze", {31'd0, MEM_WB_Freeze}, 32'd1);
      check("lb_ready", {31'd0, WB_Ready}, 32'd0);
      check("lb_pending", {31'd0, Fwd_Pending}, 32'd1);
      check("lb_addr_held", {27'd0, RD_Write_Addr}, 32'd9);
      if (i != 2) step();
    end
    DMEM_RValid = 1'b1; DMEM_RData = 32'h80FF_0000;
    push_wr(5'd9, 32'hFFFF_FF80, 1'b0);
    step();
    DMEM_RValid = 1'b0; DMEM_RData = 32'd0;
    check("lb_unfreeze", {31'd0, MEM_WB_Freeze}, 32'd0);
    step();

    load_with_data(5'd10, 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);  // LHU
    load_with_data(5'd11, 3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001);  // LH
    load_with_data(5'd12, 3'b100, 2'd1, 32'h0000_F000, 32'h0000_00F0);  // LBU
    load_with_data(5'd13, 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);  // LW

    // Misaligned LW and LH
    issue(1'b1, 1'b1, 5'd14, 1'b0, 3'b010, 2'd1, 32'd0);
    push_err(1'b1, 1'b0);
    step();
    idle();
    check("lw_mis_ready", {31'd0, WB_Ready}, 32'd1);
    step();
    issue(1'b1, 1'b1, 5'd15, 1'b0, 3'b001, 2'd3, 32'd0);
    push_err(1'b1, 1'b0);
    step();
    idle();
    step();

    // Back-to-back: rd0 never writes, rd7 with IRQ bank
    issue(1'b0, 1'b1, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0000_DEAD);
    step();
    check("b2b_ready", {31'd0, WB_Ready}, 32'd1);
    issue(1'b0, 1'b1, 5'd7, 1'b1, 3'd0, 2'd0, 32'h0000_CAFE);
    push_wr(5'd7, 32'h0000_CAFE, 1'b1);
    step();
    idle();
    step();

    // Stray RValid outside WAIT is ignored
    DMEM_RValid = 1'b1; DMEM_RData = 32'h1111_1111;
    step();
    DMEM_RValid = 1'b0;
    step();
    check("stray_rvalid_ready", {31'd0, WB_Ready}, 32'd1);

    // Reset during WAIT aborts the load
    issue(1'b1, 1'b1, 5'd16, 1'b0, 3'b010, 2'd0, 32'd0);
    step();
    idle();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("abort_freeze", {31'd0, MEM_WB_Freeze}, 32'd0);
    DMEM_RValid = 1'b1; DMEM_RData = 32'h2222_2222;
    step();
    DMEM_RValid = 1'b0;
    step();

`ifdef LOAD_TIMEOUT_EN
    issue(1'b1, 1'b1, 5'd17, 1'b0, 3'b010, 2'd0, 32'd0);
    step();
    idle();
    push_err(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("to_freeze", {31'd0, MEM_WB_Freeze}, 32'd1);
      step();
    end
    check("to_empty", {31'd0, WB_Ready}, 32'd1);
    step();
`else
    issue(1'b1, 1'b1, 5'd17, 1'b0, 3'b010, 2'd0, 32'd0);
    step();
    idle();
    for (int i = 0; i < 10; i++) begin
      check("wait_persists", {31'd0, MEM_WB_Freeze}, 32'd1);
      step();
    end
    DMEM_RValid = 1'b1; DMEM_RData = 32'h1234_5678;
    push_wr(5'd17, 32'h1234_5678, 1'b0);
    step();
    DMEM_RValid = 1'b0;
    step();
`endif

    step();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
